// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing bus of the branch predictor controller.
// master = pipeline side (fetch + execute), slave = predictor controller.
interface branch_predictor_if #(
  parameter int PC_W   = 32,
  parameter int STAT_W = 16
);
  logic              pred_valid;
  logic [PC_W-1:0]   pred_pc;
  logic              pred_out_valid;
  logic              pred_taken;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken;
  logic              upd_pred;
  logic              busy;
  logic [STAT_W-1:0] stat_updates;
  logic [STAT_W-1:0] stat_mispred;

  modport master (
    output pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_pred,
    input  pred_out_valid, pred_taken, busy, stat_updates, stat_mispred
  );

  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_pred,
    output pred_out_valid, pred_taken, busy, stat_updates, stat_mispred
  );
endinterface

// File: rtl/branch_predictor_ctrl.sv
// Table of 2-bit saturating direction counters indexed by pc[IDX_W+1:2].
// One registered prediction and one read-modify-write update per cycle,
// a post-reset sweep that sets every entry to WNT, and saturating stats.
//
// state | meaning
// INIT  | sweeping entry sweep_idx to WNT; requests and updates ignored
// RUN   | serving predictions and applying updates
module branch_predictor_ctrl #(
  parameter int IDX_W  = 6,
  parameter int PC_W   = 32,
  parameter int STAT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_predictor_if.slave  bus
);
  localparam int ENTRIES = 2**IDX_W;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  sweep_idx_q;
  logic [1:0]        ctr_q [ENTRIES];

  logic [IDX_W-1:0]  pred_idx, upd_idx;
  logic [1:0]        upd_old, upd_new;
  logic              upd_accept;

  logic              pred_out_valid_q, pred_out_valid_d;
  logic              pred_taken_q, pred_taken_d;
  logic              busy_q, busy_d;
  logic [STAT_W-1:0] stat_updates_q, stat_updates_d;
  logic [STAT_W-1:0] stat_mispred_q, stat_mispred_d;

  logic              unused_pc_bits;

  assign pred_idx = bus.pred_pc[IDX_W+1:2];
  assign upd_idx  = bus.upd_pc[IDX_W+1:2];

  // PC bits outside the index field do not select an entry.
  assign unused_pc_bits = ^{bus.pred_pc[PC_W-1:IDX_W+2], bus.pred_pc[1:0],
                            bus.upd_pc[PC_W-1:IDX_W+2], bus.upd_pc[1:0]};

  // State register; reset always restarts the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  // Next state: leave INIT right after the last entry has been written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (sweep_idx_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Saturating counter step for the resolved branch.
  always_comb begin
    upd_accept = (state_q == RUN) && bus.upd_valid;
    upd_old    = ctr_q[upd_idx];
    upd_new    = upd_old;
    if (bus.upd_taken) begin
      if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
    end else begin
      if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
    end
  end

  // Output next-values; same-index update is forwarded to the prediction.
  always_comb begin
    pred_out_valid_d = (state_q == RUN) && bus.pred_valid;
    pred_taken_d     = 1'b0;
    if (pred_out_valid_d) begin
      if (upd_accept && (upd_idx == pred_idx)) pred_taken_d = upd_new[1];
      else                                     pred_taken_d = ctr_q[pred_idx][1];
    end
    busy_d = (state_d == INIT);
    stat_updates_d = stat_updates_q;
    stat_mispred_d = stat_mispred_q;
    if (upd_accept && (stat_updates_q != '1))
      stat_updates_d = stat_updates_q + 1'b1;
    if (upd_accept && (bus.upd_pred != bus.upd_taken) && (stat_mispred_q != '1))
      stat_mispred_d = stat_mispred_q + 1'b1;
  end

  // Registered outputs, sweep pointer and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_idx_q      <= '0;
      pred_out_valid_q <= 1'b0;
      pred_taken_q     <= 1'b0;
      busy_q           <= 1'b1;
      stat_updates_q   <= '0;
      stat_mispred_q   <= '0;
    end else begin
      if (state_q == INIT) sweep_idx_q <= sweep_idx_q + 1'b1;
      pred_out_valid_q <= pred_out_valid_d;
      pred_taken_q     <= pred_taken_d;
      busy_q           <= busy_d;
      stat_updates_q   <= stat_updates_d;
      stat_mispred_q   <= stat_mispred_d;
    end
  end

  // Counter table: no reset, the sweep is its only initialisation.
  always_ff @(posedge clk) begin
    if (state_q == INIT)  ctr_q[sweep_idx_q] <= 2'b01;
    else if (upd_accept)  ctr_q[upd_idx]     <= upd_new;
  end

  assign bus.pred_out_valid = pred_out_valid_q;
  assign bus.pred_taken     = pred_taken_q;
  assign bus.busy           = busy_q;
  assign bus.stat_updates   = stat_updates_q;
  assign bus.stat_mispred   = stat_mispred_q;
endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Self-checking bench for branch_predictor_ctrl (IDX_W=6, STAT_W=4).
module tb_branch_predictor_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  branch_predictor_if #(.PC_W(32), .STAT_W(4)) bp ();

  branch_predictor_ctrl #(.IDX_W(6), .PC_W(32), .STAT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bp)
  );

  typedef struct {
    logic        pv;
    logic [31:0] ppc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        up;
    logic        ev;
    logic        et;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] sb[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bp.pred_valid = 1'b0;
    bp.pred_pc    = '0;
    bp.upd_valid  = 1'b0;
    bp.upd_pc     = '0;
    bp.upd_taken  = 1'b0;
    bp.upd_pred   = 1'b0;
  endtask

  task automatic step(input vec_t v, input string name);
    logic [1:0] e;
    @(negedge clk);
    bp.pred_valid = v.pv;
    bp.pred_pc    = v.ppc;
    bp.upd_valid  = v.uv;
    bp.upd_pc     = v.upc;
    bp.upd_taken  = v.ut;
    bp.upd_pred   = v.up;
    sb.push_back({v.ev, v.et});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({name, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, " valid"}, bp.pred_out_valid, e[1]);
      chk({name, " taken"}, bp.pred_taken, e[0]);
    end
  endtask

  // Called at a negedge just after reset release; counts cycles with busy high.
  task automatic sweep_check(input string tag);
    int cyc  = 0;
    int povs = 0;
    while (bp.busy === 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bp.pred_out_valid !== 1'b0) povs++;
    end
    chk({tag, " busy cycles"}, cyc, 64);
    chk({tag, " pred_out_valid in init"}, povs, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, bp.busy, 1);
    chk({tag, " pred_out_valid"}, bp.pred_out_valid, 0);
    chk({tag, " pred_taken"}, bp.pred_taken, 0);
    chk({tag, " stat_updates"}, bp.stat_updates, 0);
    chk({tag, " stat_mispred"}, bp.stat_mispred, 0);
  endtask

  initial begin
    vec_t v;

    //            pv  ppc       uv  upc       ut  up  ev  et
    vecs.push_back('{1'b1, 32'h80,  1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 32'h40,  1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 32'h0,   1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 32'h0,   1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 32'h40,  1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 32'h40,  1'b1, 32'h40, 1'b1, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 32'h0,   1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 32'h40,  1'b1, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 32'h40,  1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'h0,   1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 32'h40,  1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 32'h80,  1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 32'h84,  1'b1, 32'h80, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 32'h43,  1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 32'hFC,  1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 32'h180, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1});

    drive_idle();

    // Power-on reset: outputs take reset values asynchronously.
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("por");
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("por held");

    // First sweep, interrupted part-way by reset.
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("mid-sweep rst");

    // Restarted sweep with requests and updates hammering entry 0x80.
    @(negedge clk);
    bp.pred_valid = 1'b1;
    bp.pred_pc    = 32'h80;
    bp.upd_valid  = 1'b1;
    bp.upd_pc     = 32'h80;
    bp.upd_taken  = 1'b1;
    bp.upd_pred   = 1'b0;
    rst_n = 1'b1;
    sweep_check("sweep1");
    drive_idle();
    chk("init stat_updates", bp.stat_updates, 0);
    chk("init stat_mispred", bp.stat_mispred, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end
    #1;
    chk("run stat_updates", bp.stat_updates, 9);
    chk("run stat_mispred", bp.stat_mispred, 4);

    // Mid-RUN reset while pred_out_valid/pred_taken are both high.
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid-run rst");
    drive_idle();
    @(negedge clk) rst_n = 1'b1;
    sweep_check("sweep2");

    // Entry 0x80 was ST before reset; the sweep must bring it back to WNT.
    v = '{1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    step(v, "resweep 0x80");

    // 20 mispredicted updates saturate both 4-bit statistics.
    for (int i = 0; i < 20; i++) begin
      v = '{1'b0, 32'h0, 1'b1, 32'(i * 4), i[0], ~i[0], 1'b0, 1'b0};
      step(v, $sformatf("sat%0d", i));
    end
    drive_idle();
    @(posedge clk);
    #1;
    chk("sat stat_updates", bp.stat_updates, 15);
    chk("sat stat_mispred", bp.stat_mispred, 15);
    chk("scoreboard drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
